// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle MIPS mul/div sequencer.
package muldiv_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider registers, sign fix and HI/LO.
// Operands are latched as magnitudes; sign correction happens once in FIX.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mul_step,
    input  logic            div_step,
    input  logic            fix_wr,
    output logic            mul_rest_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [2*XLEN-1:0] acc_q, acc_d;   // product / {remainder, quotient}
    logic [2*XLEN-1:0] mc_q, mc_d;     // shifted multiplicand / divisor in low half
    logic [XLEN-1:0]   mlt_q, mlt_d;   // unconsumed multiplier bits
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;   // negate product / quotient
    logic              rneg_q, rneg_d; // negate remainder
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic              signed_op, rs_neg, rt_neg;
    logic [XLEN-1:0]   rs_abs, rt_abs;
    logic [XLEN:0]     rem_sh, diff;
    logic [2*XLEN-1:0] prod_fix;

    // Next-state for the working registers and HI/LO.
    always_comb begin
        signed_op = (muldiv_op_e'(op) == OP_MULT) || (muldiv_op_e'(op) == OP_DIV);
        rs_neg    = signed_op & rs_val[XLEN-1];
        rt_neg    = signed_op & rt_val[XLEN-1];
        rs_abs    = rs_neg ? -rs_val : rs_val;
        rt_abs    = rt_neg ? -rt_val : rt_val;
        rem_sh    = acc_q[2*XLEN-1:XLEN-1];
        diff      = rem_sh - {1'b0, mc_q[XLEN-1:0]};
        prod_fix  = neg_q ? -acc_q : acc_q;

        acc_d    = acc_q;
        mc_d     = mc_q;
        mlt_d    = mlt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (load) begin
            is_div_d = op[1];
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = rs_neg;
            if (op[1] && rt_val == '0) begin
                // Divide by zero: preload the final answer, FIX passes it through.
                acc_d  = {rs_val, {XLEN{1'b1}}};
                neg_d  = 1'b0;
                rneg_d = 1'b0;
            end else if (op[1]) begin
                acc_d = {{XLEN{1'b0}}, rs_abs};
                mc_d  = {{XLEN{1'b0}}, rt_abs};
            end else begin
                acc_d = '0;
                mc_d  = {{XLEN{1'b0}}, rs_abs};
                mlt_d = rt_abs;
            end
        end else if (mul_step) begin
            if (mlt_q[0]) acc_d = acc_q + mc_q;
            mc_d  = mc_q << 1;
            mlt_d = mlt_q >> 1;
        end else if (div_step) begin
            // rem_sh is one bit wider so 2*rem never overflows before the compare.
            if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        if (fix_wr) begin
            if (is_div_q) begin
                hi_d = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                lo_d = neg_q  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
            end else begin
                hi_d = prod_fix[2*XLEN-1:XLEN];
                lo_d = prod_fix[XLEN-1:0];
            end
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mc_q     <= '0;
            mlt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mlt_q    <= mlt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign mul_rest_zero = (mlt_q[XLEN-1:1] == '0);
    assign hi            = hi_q;
    assign lo            = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Build option: MULDIV_EARLY_OUT_EN ends a multiply once the remaining
// multiplier bits are zero; division latency is fixed in both builds.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    input  logic            mfhi_req,
    input  logic            mflo_req,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, mul_step, div_step, fix_wr, mul_rest_zero;

    // Next-state, counter and datapath controls.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        mul_step = 1'b0;
        div_step = 1'b0;
        fix_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    load  = 1'b1;
                    cnt_d = CNT_W'(XLEN - 1);
                    if (op[1] && rt_val == '0) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end else if (op[1]) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0 || (EARLY_OUT && mul_rest_zero)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end
            S_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end
            S_FIX: begin
                fix_wr  = !flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A squash abandons the op; working registers are simply left stale.
        if (flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .op            (op),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .mul_step      (mul_step),
        .div_step      (div_step),
        .fix_wr        (fix_wr),
        .mul_rest_zero (mul_rest_zero),
        .hi            (hi),
        .lo            (lo)
    );

    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | mfhi_req | mflo_req);
    assign done  = (state_q == S_FIX) & ~flush;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed spec vectors plus
// randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, flush, mfhi_req, mflo_req;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall, done;
    logic [31:0] hi, lo;
    int          checks = 0;
    int          errors = 0;

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .flush(flush), .mfhi_req(mfhi_req), .mflo_req(mflo_req),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Expected HI/LO and busy-cycle count from plain 64-bit arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el, output int lat);
        longint      sa, sb, ua, ub, q, r;
        logic [63:0] p;
        logic [31:0] mag;
        int          n;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        lat = 33;
        eh = '0; el = '0;
        case (o)
            2'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            2'd1: begin p = 64'(ua * ub); eh = p[63:32]; el = p[31:0]; end
            2'd2: if (b == 0) begin eh = a; el = '1; lat = 1; end
                  else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
            default: if (b == 0) begin eh = a; el = '1; lat = 1; end
                  else begin q = ua / ub; r = ua % ub; el = q[31:0]; eh = r[31:0]; end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (o[1] == 1'b0) begin
            mag = (o == 2'd0 && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
            lat = n + 1;
        end
`else
        mag = '0; n = 0;
`endif
    endfunction

    // Issue one op and check result, busy length and a single done pulse.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [31:0] eh, el;
        int exp_lat, lat, dn;
        ref_model(o, a, b, eh, el, exp_lat);
        @(negedge clk); start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk); start = 1'b0;
        lat = 0; dn = 0;
        while (busy && lat < 200) begin
            lat++;
            if (done) dn++;
            @(negedge clk);
        end
        checks += 4;
        if (hi !== eh) begin errors++; $display("FAIL %s hi got %h exp %h", nm, hi, eh); end
        if (lo !== el) begin errors++; $display("FAIL %s lo got %h exp %h", nm, lo, el); end
        if (lat != exp_lat) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", nm, lat, exp_lat); end
        if (dn != 1) begin errors++; $display("FAIL %s done_pulses got %0d exp 1", nm, dn); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; flush = 0; mfhi_req = 0; mflo_req = 0; op = 0; rs_val = 0; rt_val = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, stall, done, hi, lo} !== '0) begin
            errors++; $display("FAIL reset busy %b stall %b done %b hi %h lo %h exp all 0", busy, stall, done, hi, lo);
        end
    endtask

    task automatic test_directed();
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'd0, -32'sd7, 32'd3, "mult_neg");
        run_op(2'd2, -32'sd7, 32'd2, "div_neg");
        run_op(2'd3, 32'd100, 32'd0, "divu_zero");
        run_op(2'd2, 32'd55, 32'd0, "div_zero");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'd1, 32'd5, 32'd3, "multu_small");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            if (i % 6 == 5) b = '0;
            if (i % 4 == 3) b = b >> $urandom_range(31, 0);
            run_op(2'($urandom_range(3, 0)), a, b, "random");
        end
    endtask

    // mflo held from busy cycle 10; a second start mid-op must be ignored.
    task automatic test_stall();
        logic [31:0] a, b, eh, el;
        int lat, exp_lat, bad;
        a = $urandom; b = $urandom | 32'h8000_0000;
        ref_model(2'd1, a, b, eh, el, exp_lat);
        @(negedge clk); mfhi_req = 1'b1; #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL idle_mfhi stall got %b exp 0", stall); end
        mfhi_req = 1'b0;
        start = 1'b1; op = 2'd1; rs_val = a; rt_val = b;
        @(negedge clk); start = 1'b0;
        lat = 0; bad = 0;
        while (busy && lat < 200) begin
            lat++;
            mflo_req = (lat >= 10);
            start = (lat == 3);
            op = 2'd3; rs_val = 32'd9; rt_val = 32'd0;
            #1;
            if (stall !== (lat >= 10 || lat == 3)) bad++;
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        checks += 3;
        if (bad != 0) begin errors++; $display("FAIL stall_window bad_cycles got %0d exp 0", bad); end
        if (stall !== 1'b0 || lo !== el) begin
            errors++; $display("FAIL stall_release stall %b lo %h exp 0 %h", stall, lo, el);
        end
        if (lat != exp_lat) begin errors++; $display("FAIL stall_latency got %0d exp %0d", lat, exp_lat); end
        mflo_req = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] oh, ol;
        int dn;
        oh = hi; ol = lo; dn = 0;
        @(negedge clk); start = 1'b1; op = 2'd3; rs_val = 32'd1000; rt_val = 32'd7;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c < 5; c++) begin if (done) dn++; @(negedge clk); end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== oh || lo !== ol || dn != 0) begin
            errors++; $display("FAIL flush_mid busy %b hi %h lo %h done %0d exp 0 %h %h 0", busy, hi, lo, dn, oh, ol);
        end
        // Flush in FIX: no done, no HI/LO write.
        @(negedge clk); start = 1'b1; op = 2'd3; rs_val = 32'd77; rt_val = 32'd0;
        @(negedge clk); start = 1'b0; flush = 1'b1; #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL flush_fix_done got %b exp 0", done); end
        @(negedge clk); flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== oh || lo !== ol) begin
            errors++; $display("FAIL flush_fix busy %b hi %h lo %h exp 0 %h %h", busy, hi, lo, oh, ol);
        end
        // Flush and start together in IDLE: start dropped.
        start = 1'b1; flush = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_start busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        run_op(2'd1, 32'd12345, 32'd678, "pre_rst");
        @(negedge clk); start = 1'b1; op = 2'd2; rs_val = 32'd999; rt_val = 32'd5;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== '0) begin
            errors++; $display("FAIL reset_mid busy %b done %b hi %h lo %h exp all 0", busy, done, hi, lo);
        end
        run_op(2'd0, 32'd6, -32'sd9, "post_rst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
